// File: rtl/piton_aws_axi_scratch_responder_if.sv
// AXI4 bus between a translated initiator (master) and the scratch
// responder (slave). Every beat is one 64-byte word; size fields are
// not carried.
//
// Handshake: a channel transfers on a rising clk edge where its valid and
// ready are both high. Once valid is raised it and its payload stay stable
// until that transfer; ready may change freely and never waits on valid
// combinationally.
interface axi_bus_t;
  // write address
  logic [5:0]   awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  // write data
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  // write response
  logic [5:0]   bid;
  logic [1:0]   bresp;
  logic         buser;
  logic         bvalid;
  logic         bready;
  // read address
  logic [5:0]   arid;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  // read data
  logic [5:0]   rid;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         ruser;
  logic         rvalid;
  logic         rready;
  // responder FSM state, for observation only
  logic [1:0]   w_state_dbg;
  logic         r_state_dbg;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    output rready,
    input  awready, wready,
    input  bid, bresp, buser, bvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    input  w_state_dbg, r_state_dbg
  );

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    input  rready,
    output awready, wready,
    output bid, bresp, buser, bvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    output w_state_dbg, r_state_dbg
  );
endinterface

// File: rtl/piton_aws_axi_scratch_responder.sv
// AXI4 scratch-memory responder: DEPTH_WORDS 64-byte words at BASE_ADDR,
// one outstanding write and one outstanding read, independent FSMs.
module piton_aws_axi_scratch_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'hc00000000,
  parameter int          DEPTH_WORDS = 16
) (
  input logic clk,
  input logic rst_n,
  axi_bus_t.slave s_axi
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd64;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  function automatic logic in_range(input logic [63:0] addr);
    return (addr >= BASE_ADDR) && (addr < END_ADDR);
  endfunction

  function automatic logic [63:0] word_of(input logic [63:0] addr);
    return (addr - BASE_ADDR) >> 6;
  endfunction

  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  // scratch storage; deliberately has no reset
  logic [511:0] mem_q [DEPTH_WORDS];

  // ---------------- write side ----------------
  w_state_e    w_state_q, w_state_d;
  logic        rdy_en_q;
  logic [5:0]  aw_id_q;
  logic [63:0] w_addr_q;
  logic [7:0]  aw_len_q;
  logic [1:0]  aw_burst_q;
  logic [8:0]  w_cnt_q;
  logic        w_dec_q;
  logic [1:0]  b_resp_q;

  logic             aw_hs, w_hs, b_hs;
  logic             w_legal, w_in_range, w_we, w_count_ok;
  logic [63:0]      w_word;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       b_resp_d;

  assign aw_hs      = s_axi.awvalid && s_axi.awready;
  assign w_hs       = s_axi.wvalid && s_axi.wready;
  assign b_hs       = s_axi.bvalid && s_axi.bready;
  assign w_legal    = burst_ok(aw_burst_q);
  assign w_in_range = in_range(w_addr_q);
  assign w_word     = word_of(w_addr_q);
  assign w_idx      = w_word[IDX_W-1:0];
  assign w_we       = rst_n && w_hs && w_in_range && w_legal;
  // w_cnt_q counts earlier beats, so the wlast beat is number w_cnt_q+1
  assign w_count_ok = (w_cnt_q == {1'b0, aw_len_q});

  assign b_resp_d = (w_dec_q || !w_in_range)   ? RESP_DECERR :
                    (!w_legal || !w_count_ok)  ? RESP_SLVERR : RESP_OKAY;

  assign s_axi.awready     = rdy_en_q && (w_state_q == W_IDLE);
  assign s_axi.wready      = (w_state_q == W_DATA);
  assign s_axi.bvalid      = (w_state_q == W_RESP);
  assign s_axi.bid         = aw_id_q;
  assign s_axi.bresp       = b_resp_q;
  assign s_axi.buser       = 1'b0;
  assign s_axi.w_state_dbg = w_state_q;

  // write FSM next state
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && s_axi.wlast) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // write FSM state, captured AW fields, beat tracking and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      rdy_en_q   <= 1'b0;
      aw_id_q    <= '0;
      w_addr_q   <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_dec_q    <= 1'b0;
      b_resp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      rdy_en_q  <= 1'b1;
      if (aw_hs) begin
        aw_id_q    <= s_axi.awid;
        w_addr_q   <= s_axi.awaddr;
        aw_len_q   <= s_axi.awlen;
        aw_burst_q <= s_axi.awburst;
        w_cnt_q    <= '0;
        w_dec_q    <= 1'b0;
      end
      if (w_hs) begin
        // illegal bursts hold the address like FIXED; their beats are dropped
        if (aw_burst_q == BURST_INCR) w_addr_q <= w_addr_q + 64'd64;
        if (w_cnt_q != 9'h1ff) w_cnt_q <= w_cnt_q + 9'd1;
        if (!w_in_range) w_dec_q <= 1'b1;
        if (s_axi.wlast) b_resp_q <= b_resp_d;
      end
    end
  end

  // byte-enabled scratch write; a later beat to the same word overrides
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 64; b++) begin
        if (s_axi.wstrb[b]) mem_q[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read side ----------------
  r_state_e     r_state_q, r_state_d;
  logic [5:0]   r_id_q;
  logic [63:0]  r_addr_q;
  logic [7:0]   r_len_q;
  logic [1:0]   r_burst_q;
  logic [7:0]   r_cnt_q;
  logic [511:0] r_data_q;
  logic [1:0]   r_resp_q;
  logic         r_last_q;

  logic             ar_hs, r_hs, r_load;
  logic [63:0]      r_src_addr;
  logic [1:0]       r_src_burst;
  logic             r_src_legal, r_src_in_range, r_next_last;
  logic [63:0]      r_word;
  logic [IDX_W-1:0] r_src_idx;
  logic [511:0]     r_mem_word;

  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs  = s_axi.rvalid && s_axi.rready;
  // a beat is loaded on the AR handshake and on every non-final R handshake,
  // so the stored word is the contents just before the beat goes valid
  assign r_load         = ar_hs || (r_hs && !r_last_q);
  assign r_src_addr     = ar_hs ? s_axi.araddr : r_addr_q;
  assign r_src_burst    = ar_hs ? s_axi.arburst : r_burst_q;
  assign r_src_legal    = burst_ok(r_src_burst);
  assign r_src_in_range = in_range(r_src_addr);
  assign r_word         = word_of(r_src_addr);
  assign r_src_idx      = r_word[IDX_W-1:0];
  assign r_mem_word     = mem_q[r_src_idx];
  assign r_next_last    = ar_hs ? (s_axi.arlen == 8'd0)
                                : ((r_cnt_q + 8'd1) == r_len_q);

  assign s_axi.arready     = rdy_en_q && (r_state_q == R_IDLE);
  assign s_axi.rvalid      = (r_state_q == R_DATA);
  assign s_axi.rid         = r_id_q;
  assign s_axi.rdata       = r_data_q;
  assign s_axi.rresp       = r_resp_q;
  assign s_axi.rlast       = r_last_q && (r_state_q == R_DATA);
  assign s_axi.ruser       = 1'b0;
  assign s_axi.r_state_dbg = r_state_q;

  logic unused_word_bits;
  assign unused_word_bits = ^{w_word[63:IDX_W], r_word[63:IDX_W]};

  // read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && r_last_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // read FSM state, captured AR fields and the presented beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      r_last_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_id_q    <= s_axi.arid;
        r_len_q   <= s_axi.arlen;
        r_burst_q <= s_axi.arburst;
        r_cnt_q   <= '0;
      end else if (r_load) begin
        r_cnt_q <= r_cnt_q + 8'd1;
      end
      if (r_load) begin
        r_data_q <= (r_src_in_range && r_src_legal) ? r_mem_word : '0;
        r_resp_q <= !r_src_in_range ? RESP_DECERR :
                    !r_src_legal    ? RESP_SLVERR : RESP_OKAY;
        r_last_q <= r_next_last;
        r_addr_q <= (r_src_burst == BURST_INCR) ? r_src_addr + 64'd64 : r_src_addr;
      end
    end
  end

endmodule

// File: tb/tb_piton_aws_axi_scratch_responder.sv
// Directed bench for the scratch responder: reset, single and burst
// transfers, decode/burst errors, strobes, mid-burst reset, same-cycle
// write/read ordering.
module tb_piton_aws_axi_scratch_responder;

  localparam logic [63:0] BASE = 64'hc00000000;
  localparam logic [1:0]  FIXED = 2'b00;
  localparam logic [1:0]  INCR  = 2'b01;
  localparam logic [1:0]  WRAP  = 2'b10;
  localparam logic [63:0] P_BURST = 64'h1111_2222_0000_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [511:0] rd_data [16];
  logic [1:0]   rd_resp [16];
  logic         rd_last [16];
  int           rd_n;
  logic [5:0]   next_id;

  axi_bus_t s_axi ();

  piton_aws_axi_scratch_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_axi (s_axi)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] beat_data(input logic [63:0] pat, input int i);
    logic [63:0] w;
    w = pat + 64'(i);
    return {8{w}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats,
                          input logic [63:0] pat, input logic [63:0] strb_last,
                          output logic [1:0] resp);
    int t;
    logic [5:0] id;
    id = next_id;
    next_id = next_id + 6'd1;
    resp = 2'bxx;
    @(negedge clk);
    s_axi.awvalid = 1'b1; s_axi.awaddr = addr; s_axi.awlen = len;
    s_axi.awburst = burst; s_axi.awid = id;
    t = 0;
    while (!s_axi.awready && t < 20) begin @(negedge clk); t++; end
    if (t == 20) begin checks++; errors++; $display("FAIL aw_timeout: awready=0 required 1"); end
    @(negedge clk);
    s_axi.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_axi.wvalid = 1'b1;
      s_axi.wdata  = beat_data(pat, i);
      s_axi.wstrb  = (i == nbeats - 1) ? strb_last : '1;
      s_axi.wlast  = (i == nbeats - 1);
      t = 0;
      while (!s_axi.wready && t < 20) begin @(negedge clk); t++; end
      if (t == 20) begin checks++; errors++; $display("FAIL w_timeout: wready=0 required 1"); end
      @(negedge clk);
    end
    s_axi.wvalid = 1'b0;
    s_axi.wlast  = 1'b0;
    s_axi.bready = 1'b1;
    t = 0;
    while (!s_axi.bvalid && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (t == 20) begin
      errors++; $display("FAIL b_timeout: bvalid=0 required 1");
    end else begin
      resp = s_axi.bresp;
      if (s_axi.bid !== id) begin
        errors++; $display("FAIL bid: got %h required %h", s_axi.bid, id);
      end
    end
    @(negedge clk);
    s_axi.bready = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int nbeats, input bit toggle);
    int t;
    int cyc;
    bit stalled;
    logic [511:0] h_data;
    logic [1:0]   h_resp;
    logic         h_last;
    logic [5:0]   id;
    id = next_id;
    next_id = next_id + 6'd1;
    rd_n = 0;
    @(negedge clk);
    s_axi.arvalid = 1'b1; s_axi.araddr = addr; s_axi.arlen = len;
    s_axi.arburst = burst; s_axi.arid = id;
    t = 0;
    while (!s_axi.arready && t < 20) begin @(negedge clk); t++; end
    if (t == 20) begin checks++; errors++; $display("FAIL ar_timeout: arready=0 required 1"); end
    @(negedge clk);
    s_axi.arvalid = 1'b0;
    // first beat must be valid in the cycle right after the AR handshake
    checks++;
    if (s_axi.rvalid !== 1'b1) begin
      errors++; $display("FAIL r_latency: rvalid=%b required 1", s_axi.rvalid);
    end
    cyc = 0;
    stalled = 0;
    h_data = '0; h_resp = '0; h_last = 1'b0;
    while (rd_n < nbeats && cyc < 200) begin
      s_axi.rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (stalled) begin
        checks++;
        if (s_axi.rdata !== h_data || s_axi.rresp !== h_resp || s_axi.rlast !== h_last) begin
          errors++;
          $display("FAIL r_hold: beat %0d rresp=%b rlast=%b changed from rresp=%b rlast=%b", rd_n, s_axi.rresp, s_axi.rlast, h_resp, h_last);
        end
      end
      if (s_axi.rvalid && s_axi.rready) begin
        checks++;
        if (s_axi.rid !== id) begin
          errors++; $display("FAIL rid: got %h required %h", s_axi.rid, id);
        end
        rd_data[rd_n] = s_axi.rdata;
        rd_resp[rd_n] = s_axi.rresp;
        rd_last[rd_n] = s_axi.rlast;
        rd_n++;
        stalled = 0;
      end else if (s_axi.rvalid) begin
        stalled = 1;
        h_data = s_axi.rdata; h_resp = s_axi.rresp; h_last = s_axi.rlast;
      end else begin
        stalled = 0;
      end
      @(negedge clk);
      cyc++;
    end
    s_axi.rready = 1'b0;
    checks++;
    if (rd_n < nbeats) begin
      errors++; $display("FAIL r_timeout: got %0d beats required %0d", rd_n, nbeats);
    end else if (s_axi.rvalid !== 1'b0 || s_axi.arready !== 1'b1) begin
      errors++; $display("FAIL r_idle: rvalid=%b arready=%b required 0/1", s_axi.rvalid, s_axi.arready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid, s_axi.rlast} !== 6'b0 ||
        s_axi.bresp !== 2'b00 || s_axi.rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: aw/w/b/ar/r/rlast=%b%b%b%b%b%b bresp=%b rresp=%b required all 0",
               s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid, s_axi.rlast,
               s_axi.bresp, s_axi.rresp);
    end
    rst_n = 1'b1;
    checks++;
    if (s_axi.awready !== 1'b0 || s_axi.arready !== 1'b0) begin
      errors++; $display("FAIL reset_release_early: awready=%b arready=%b required 0", s_axi.awready, s_axi.arready);
    end
    @(negedge clk);
    checks++;
    if (s_axi.awready !== 1'b1 || s_axi.arready !== 1'b1) begin
      errors++; $display("FAIL reset_release: awready=%b arready=%b required 1", s_axi.awready, s_axi.arready);
    end
  endtask

  task automatic test_single;
    logic [1:0] resp;
    logic [63:0] pat;
    pat = 64'hd00d_f00d_1234_5678;
    do_write(BASE + 64'h40, 8'd0, INCR, 1, pat, '1, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b required 00", resp); end
    do_read(BASE + 64'h40, 8'd0, INCR, 1, 0);
    checks++;
    if (rd_data[0] !== beat_data(pat, 0) || rd_resp[0] !== 2'b00 || rd_last[0] !== 1'b1) begin
      errors++; $display("FAIL single_read: rresp=%b rlast=%b data_ok=%b required 00/1/1",
                         rd_resp[0], rd_last[0], rd_data[0] === beat_data(pat, 0));
    end
  endtask

  task automatic test_burst;
    logic [1:0] resp;
    do_write(BASE, 8'd3, INCR, 4, P_BURST, '1, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL burst_bresp: got %b required 00", resp); end
    do_read(BASE, 8'd3, INCR, 4, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== beat_data(P_BURST, i) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
        errors++; $display("FAIL burst_beat%0d: rresp=%b rlast=%b data_ok=%b required 00/%0d/1",
                           i, rd_resp[i], rd_last[i], rd_data[i] === beat_data(P_BURST, i), i == 3);
      end
    end
  endtask

  task automatic test_decerr;
    logic [1:0] resp;
    logic [63:0] pat15;
    pat15 = 64'h0f0f_0f0f_1515_1515;
    do_write(BASE + 64'h3c0, 8'd0, INCR, 1, pat15, '1, resp);
    do_write(BASE + 64'h400, 8'd0, INCR, 1, 64'hbad0_bad0_bad0_bad0, '1, resp);
    checks++;
    if (resp !== 2'b11) begin errors++; $display("FAIL decerr_bresp: got %b required 11", resp); end
    do_read(BASE + 64'h400, 8'd0, INCR, 1, 0);
    checks++;
    if (rd_data[0] !== 512'd0 || rd_resp[0] !== 2'b11) begin
      errors++; $display("FAIL decerr_read: rresp=%b data_zero=%b required 11/1", rd_resp[0], rd_data[0] === 512'd0);
    end
    // burst straddling the top: word 15 then one past the end
    do_read(BASE + 64'h3c0, 8'd1, INCR, 2, 0);
    checks++;
    if (rd_data[0] !== beat_data(pat15, 0) || rd_resp[0] !== 2'b00 ||
        rd_data[1] !== 512'd0 || rd_resp[1] !== 2'b11 || rd_last[1] !== 1'b1) begin
      errors++; $display("FAIL decerr_straddle: rresp0=%b rresp1=%b rlast1=%b required 00/11/1",
                         rd_resp[0], rd_resp[1], rd_last[1]);
    end
  endtask

  task automatic test_slverr;
    logic [1:0] resp;
    logic [63:0] pat9;
    pat9 = 64'h9999_0000_9999_0000;
    do_write(BASE + 64'h200, 8'd3, INCR, 2, 64'h8888_0000_0000_0000, '1, resp);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp: got %b required 10", resp); end
    do_write(BASE + 64'h240, 8'd0, INCR, 1, pat9, '1, resp);
    do_write(BASE + 64'h240, 8'd0, WRAP, 1, 64'h5a5a_5a5a_5a5a_5a5a, '1, resp);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL wrap_bresp: got %b required 10", resp); end
    do_read(BASE + 64'h240, 8'd0, INCR, 1, 0);
    checks++;
    if (rd_data[0] !== beat_data(pat9, 0) || rd_resp[0] !== 2'b00) begin
      errors++; $display("FAIL wrap_no_write: rresp=%b data_ok=%b required 00/1", rd_resp[0], rd_data[0] === beat_data(pat9, 0));
    end
    do_read(BASE + 64'h240, 8'd0, WRAP, 1, 0);
    checks++;
    if (rd_data[0] !== 512'd0 || rd_resp[0] !== 2'b10) begin
      errors++; $display("FAIL wrap_read: rresp=%b data_zero=%b required 10/1", rd_resp[0], rd_data[0] === 512'd0);
    end
  endtask

  task automatic test_fixed_strobe;
    logic [1:0] resp;
    logic [63:0] pa;
    logic [511:0] exp_w;
    pa = 64'haaaa_0000_0000_0000;
    // beat 0 writes all bytes, beat 1 only the low 32 bytes of the same word
    do_write(BASE + 64'h100, 8'd1, FIXED, 2, pa, 64'h0000_0000_ffff_ffff, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp: got %b required 00", resp); end
    exp_w = {{4{pa}}, {4{pa + 64'd1}}};
    do_read(BASE + 64'h100, 8'd0, INCR, 1, 0);
    checks++;
    if (rd_data[0] !== exp_w) begin
      errors++; $display("FAIL fixed_strobe: got %h required %h", rd_data[0][511:448], exp_w[511:448]);
    end
  endtask

  task automatic test_reset_mid_read;
    int t;
    @(negedge clk);
    s_axi.arvalid = 1'b1; s_axi.araddr = BASE; s_axi.arlen = 8'd3;
    s_axi.arburst = INCR; s_axi.arid = 6'h3e;
    t = 0;
    while (!s_axi.arready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== beat_data(P_BURST, 1)) begin
      errors++; $display("FAIL rst_beat2: rvalid=%b data_ok=%b required 1/1", s_axi.rvalid, s_axi.rdata === beat_data(P_BURST, 1));
    end
    rst_n = 1'b0;
    s_axi.rready = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axi.rvalid !== 1'b0 || s_axi.arready !== 1'b0 || s_axi.rlast !== 1'b0) begin
      errors++; $display("FAIL rst_abort: rvalid=%b arready=%b rlast=%b required 0/0/0", s_axi.rvalid, s_axi.arready, s_axi.rlast);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axi.arready !== 1'b1 || s_axi.rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_rearm: arready=%b rvalid=%b required 1/0", s_axi.arready, s_axi.rvalid);
    end
    do_read(BASE, 8'd0, INCR, 1, 0);
    checks++;
    if (rd_data[0] !== beat_data(P_BURST, 0) || rd_resp[0] !== 2'b00) begin
      errors++; $display("FAIL rst_new_read: rresp=%b data_ok=%b required 00/1", rd_resp[0], rd_data[0] === beat_data(P_BURST, 0));
    end
  endtask

  task automatic test_same_cycle;
    int t;
    logic [511:0] old_w;
    logic [511:0] new_w;
    old_w = beat_data(P_BURST, 3);
    new_w = beat_data(64'hdead_beef_0000_0003, 0);
    @(negedge clk);
    s_axi.awvalid = 1'b1; s_axi.awaddr = BASE + 64'hc0; s_axi.awlen = 8'd0;
    s_axi.awburst = INCR; s_axi.awid = 6'h07;
    t = 0;
    while (!s_axi.awready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    s_axi.awvalid = 1'b0;
    s_axi.wvalid = 1'b1; s_axi.wdata = new_w; s_axi.wstrb = '1; s_axi.wlast = 1'b1;
    s_axi.arvalid = 1'b1; s_axi.araddr = BASE + 64'hc0; s_axi.arlen = 8'd0;
    s_axi.arburst = INCR; s_axi.arid = 6'h08;
    checks++;
    if (s_axi.wready !== 1'b1 || s_axi.arready !== 1'b1) begin
      errors++; $display("FAIL same_cycle_ready: wready=%b arready=%b required 1/1", s_axi.wready, s_axi.arready);
    end
    @(negedge clk);
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0; s_axi.arvalid = 1'b0;
    s_axi.bready = 1'b1; s_axi.rready = 1'b1;
    checks++;
    if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== old_w || s_axi.rid !== 6'h08) begin
      errors++; $display("FAIL same_cycle_old: rvalid=%b rid=%h old_ok=%b required 1/08/1", s_axi.rvalid, s_axi.rid, s_axi.rdata === old_w);
    end
    checks++;
    if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== 2'b00 || s_axi.bid !== 6'h07) begin
      errors++; $display("FAIL same_cycle_b: bvalid=%b bresp=%b bid=%h required 1/00/07", s_axi.bvalid, s_axi.bresp, s_axi.bid);
    end
    @(negedge clk);
    s_axi.bready = 1'b0; s_axi.rready = 1'b0;
    do_read(BASE + 64'hc0, 8'd0, INCR, 1, 0);
    checks++;
    if (rd_data[0] !== new_w) begin
      errors++; $display("FAIL same_cycle_new: got %h required %h", rd_data[0][63:0], new_w[63:0]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    next_id = 6'h01;
    rst_n = 1'b0;
    s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awburst = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arburst = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;

    test_reset();
    test_single();
    test_burst();
    test_decerr();
    test_slverr();
    test_fixed_strobe();
    test_reset_mid_read();
    test_same_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard stop in case a scenario wedges outside its own bounded waits
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past 200000 time units");
    $fatal(1, "global timeout");
  end

endmodule
